issue_trace_unit: RTL and testbench
===================================

Name: issue_trace_unit

Overview:
- Synthesizable, parametrised successor to the bench-side cycle counter and issue/result monitor.
- Sits beside the issue stage and ALU writeback of the OoO core.
- Timestamps every issue event from NUM_PORTS issue ports into a trace FIFO, and keeps saturating per-port issue and result counters.
- Trace is drained through a valid/ready read port. Supports enable, clear and overflow accounting.

Parameters:
- NUM_PORTS, 3, number of issue ports and of ALU result-valid inputs
- TAG_W, 13, captured tag width per event (opcode 7 + rd 6)
- DEPTH, 16, trace FIFO entries (power of two, >= NUM_PORTS)
- TS_W, 32, timestamp/cycle counter width
- CNT_W, 32, per-port event counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  capture/count enable
- clear  in  1  synchronous flush of FIFO and all event counters
- issue_valid  in  NUM_PORTS  per-port issue strobe
- issue_tag  in  NUM_PORTS*TAG_W  per-port tag; port p at [p*TAG_W +: TAG_W]
- result_valid  in  NUM_PORTS  per-ALU result strobe
- rd_ready  in  1  consumer accepts head entry
- rd_valid  out  1  FIFO non-empty
- rd_data  out  TS_W+PORT_W+TAG_W  {timestamp, port index, tag}; PORT_W = max(1, clog2(NUM_PORTS))
- cycle_count  out  TS_W  enabled-cycle counter
- issue_cnt  out  NUM_PORTS*CNT_W  per-port issue count
- result_cnt  out  NUM_PORTS*CNT_W  per-port result count
- drop_cnt  out  CNT_W  events lost to a full FIFO
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0

Behaviour:
- Reset (rst=1 at posedge): all counters 0, FIFO empty. rd_valid=0, empty=1, full=0, rd_data=0. rst has priority over clear and en.
- cycle_count: increments by 1 on each posedge with en=1. Holds when en=0. Wraps at 2^TS_W. Not affected by clear.
- Capture (en=1): every port with issue_valid=1 is an event stamped with the pre-increment cycle_count.
  - Events are pushed in ascending port order.
  - Free slots = DEPTH minus occupancy at the start of the cycle. A same-cycle pop does not create room.
  - If events exceed free slots, the lowest-indexed ports are kept. drop_cnt increases by the number dropped.
- Counters: issue_cnt[p] increments on issue_valid[p], including dropped events. result_cnt[p] increments on result_valid[p]. Both count only when en=1.
- Saturation: all event counters and drop_cnt saturate at 2^CNT_W-1, with no wrap.
- en=0: no captures, no event counting. Reads continue.
- Read port:
  - rd_valid = !empty. rd_data shows the head entry combinationally from FIFO storage.
  - Pop occurs when rd_valid && rd_ready. rd_ready with the FIFO empty is ignored.
- Latency: an event in cycle T is visible on rd_valid/rd_data after posedge T+1 when the FIFO was empty.
- Simultaneous push and pop: both take effect. Occupancy' = occupancy + pushed - popped.
- Pointers: wrap modulo DEPTH. Occupancy is held in a clog2(DEPTH)+1-bit counter.
- clear=1 (rst=0): FIFO emptied, and issue_cnt, result_cnt and drop_cnt zeroed. Same-cycle events and a same-cycle pop are discarded. cycle_count is unaffected.
- Reset mid-drain: the FIFO contents are lost. rd_valid falls the cycle after rst.

Decomposition:
- Shared package/header holds:
  - the entry field macros (TS/PORT/TAG slice positions)
  - the default TAG_W derived from the existing RS opcode and rd field widths
- Sub-module trace_fifo (multi-push, single-pop, parametrised DEPTH/width/NUM_PUSH) holds storage, pointers, occupancy and the accept count.
- The top holds counters, the stamping/compaction mux and drop accounting.

Test Plan:
- Reset then idle 5 cycles with en=1: cycle_count=5, empty=1, rd_valid=0, all counters 0.
- Issue on ports 0 and 2 in cycle with cycle_count=7, tags 0x0A1, 0x1F3, rd_ready=1: reads {7,0,0x0A1} then {7,2,0x1F3}. issue_cnt={1,0,1}.
- Fill to DEPTH-1 with rd_ready=0, then 3 ports issue: port 0 stored, ports 1 and 2 dropped. full=1, drop_cnt=2, issue_cnt increments on all three ports.
- Full FIFO, pop and 1 issue in the same cycle: the issue is dropped and the pop occurs; the next cycle the issue is accepted.
- en=0 for 4 cycles with issue_valid and result_valid asserted: no captures, counters and cycle_count unchanged. Reads still drain.
- clear asserted with 5 entries and nonzero counters: the next cycle empty=1, counters 0, cycle_count still incrementing. Force CNT_W=4 and issue 20 times on port 1: issue_cnt[1]=15.

Source files
------------

// File: rtl/issue_trace_unit_pkg.sv
// Shared widths and trace-entry layout for the issue trace unit.
// An entry is {timestamp, port index, tag}; the tag defaults to the RS opcode plus rd fields.
package issue_trace_unit_pkg;

  localparam int RS_OPCODE_W = 7;
  localparam int RS_RD_W     = 6;
  localparam int TRACE_TAG_W = RS_OPCODE_W + RS_RD_W;

  function automatic int port_idx_w(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Entry slice positions, LSB first: tag, then port index, then timestamp.
  function automatic int tag_lsb();
    return 0;
  endfunction

  function automatic int port_lsb(input int tag_w);
    return tag_w;
  endfunction

  function automatic int ts_lsb(input int tag_w, input int num_ports);
    return tag_w + port_idx_w(num_ports);
  endfunction

endpackage

// File: rtl/issue_trace_unit_fifo.sv
// Multi-push, single-pop trace FIFO. Accepts up to NUM_PUSH compacted entries per cycle,
// limited by the free space at the start of the cycle; reports how many were taken.
module trace_fifo #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 47,
  parameter int NUM_PUSH = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(NUM_PUSH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [CW-1:0]                      push_num,
  input  logic [NUM_PUSH-1:0][WIDTH-1:0]     push_data,
  input  logic                               rd_ready,
  output logic                               rd_valid,
  output logic [WIDTH-1:0]                   rd_data,
  output logic                               full,
  output logic                               empty,
  output logic [CW-1:0]                      accept
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [AW:0]      free_slots;
  logic             pop;

  // A same-cycle pop never frees a slot for this cycle's pushes.
  assign free_slots = (AW+1)'(DEPTH) - occ;
  assign accept     = ((AW+1)'(push_num) <= free_slots) ? push_num : CW'(free_slots);

  assign empty    = (occ == '0);
  assign full     = (occ == (AW+1)'(DEPTH));
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(accept);
      rd_ptr <= rd_ptr + AW'(pop);
      occ    <= occ + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end

  // NOTE: storage has no reset; rd_data is gated by empty so stale words never leak out.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < NUM_PUSH; i++) begin
        if (CW'(i) < accept) mem[wr_ptr + AW'(i)] <= push_data[i];
      end
    end
  end

endmodule

// File: rtl/issue_trace_unit.sv
// Issue trace unit: timestamps issue events into a trace FIFO and keeps saturating
// per-port issue/result counters plus a drop counter for events lost to a full FIFO.
module issue_trace_unit
  import issue_trace_unit_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int TAG_W     = TRACE_TAG_W,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 32,
  parameter int CNT_W     = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic                                            clear,
  input  logic [NUM_PORTS-1:0]                            issue_valid,
  input  logic [NUM_PORTS*TAG_W-1:0]                      issue_tag,
  input  logic [NUM_PORTS-1:0]                            result_valid,
  input  logic                                            rd_ready,
  output logic                                            rd_valid,
  output logic [TS_W+port_idx_w(NUM_PORTS)+TAG_W-1:0]     rd_data,
  output logic [TS_W-1:0]                                 cycle_count,
  output logic [NUM_PORTS*CNT_W-1:0]                      issue_cnt,
  output logic [NUM_PORTS*CNT_W-1:0]                      result_cnt,
  output logic [CNT_W-1:0]                                drop_cnt,
  output logic                                            full,
  output logic                                            empty
);

  localparam int PORT_W  = port_idx_w(NUM_PORTS);
  localparam int ENTRY_W = TS_W + PORT_W + TAG_W;
  localparam int CW      = $clog2(NUM_PORTS + 1);

  logic [NUM_PORTS-1:0][ENTRY_W-1:0] slot;
  logic [CW-1:0]                     push_num;
  logic [CW-1:0]                     accept;
  logic [CW-1:0]                     drop_num;
  logic [CNT_W-1:0]                  issue_q  [NUM_PORTS];
  logic [CNT_W-1:0]                  result_q [NUM_PORTS];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [CW-1:0]    inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Compaction: the k-th active port (ascending order) lands in slot k.
  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    slot     = '0;
    push_num = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (en && issue_valid[p]) begin
        for (int s = 0; s < NUM_PORTS; s++) begin
          if (push_num == CW'(s))
            slot[s] = {cycle_count, PORT_W'(p), issue_tag[p*TAG_W +: TAG_W]};
        end
        push_num = push_num + 1'b1;
      end
    end
  end

  assign drop_num = push_num - accept;

  trace_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (ENTRY_W),
    .NUM_PUSH (NUM_PORTS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push_num  (push_num),
    .push_data (slot),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .accept    (accept)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      drop_cnt    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        issue_q[p]  <= '0;
        result_q[p] <= '0;
      end
    end else begin
      if (en) cycle_count <= cycle_count + 1'b1;
      if (clear) begin
        drop_cnt <= '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
          issue_q[p]  <= '0;
          result_q[p] <= '0;
        end
      end else if (en) begin
        drop_cnt <= sat_add(drop_cnt, drop_num);
        for (int p = 0; p < NUM_PORTS; p++) begin
          issue_q[p]  <= sat_add(issue_q[p],  CW'(issue_valid[p]));
          result_q[p] <= sat_add(result_q[p], CW'(result_valid[p]));
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt_out
    assign issue_cnt[p*CNT_W +: CNT_W]  = issue_q[p];
    assign result_cnt[p*CNT_W +: CNT_W] = result_q[p];
  end

endmodule

// File: tb/tb_issue_trace_unit.sv
// Scoreboard bench for issue_trace_unit: a queue-based reference model predicts trace
// entries and counter values; a negedge monitor compares two DUTs (CNT_W=32 and CNT_W=4).
module tb_issue_trace_unit;

  localparam int NP  = 3;
  localparam int TW  = 13;
  localparam int D   = 16;
  localparam int TSW = 32;
  localparam int CW  = 32;
  localparam int SCW = 4;
  localparam int PW  = 2;
  localparam int EW  = TSW + PW + TW;

  logic            tb_clk = 1'b0;
  logic            rst, en, clear, rd_ready;
  logic [NP-1:0]   iv, rv;
  logic [NP*TW-1:0] tags;

  logic            rd_valid, full, empty;
  logic [EW-1:0]   rd_data;
  logic [TSW-1:0]  cycle_count;
  logic [NP*CW-1:0] issue_cnt, result_cnt;
  logic [CW-1:0]   drop_cnt;

  logic            s_rd_valid, s_full, s_empty;
  logic [EW-1:0]   s_rd_data;
  logic [TSW-1:0]  s_cycle_count;
  logic [NP*SCW-1:0] s_issue_cnt, s_result_cnt;
  logic [SCW-1:0]  s_drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  issue_trace_unit #(.NUM_PORTS(NP), .TAG_W(TW), .DEPTH(D), .TS_W(TSW), .CNT_W(CW)) dut (
    .clk(tb_clk), .rst(rst), .en(en), .clear(clear), .issue_valid(iv), .issue_tag(tags),
    .result_valid(rv), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .cycle_count(cycle_count), .issue_cnt(issue_cnt), .result_cnt(result_cnt),
    .drop_cnt(drop_cnt), .full(full), .empty(empty)
  );

  issue_trace_unit #(.NUM_PORTS(NP), .TAG_W(TW), .DEPTH(D), .TS_W(TSW), .CNT_W(SCW)) dut_small (
    .clk(tb_clk), .rst(rst), .en(en), .clear(clear), .issue_valid(iv), .issue_tag(tags),
    .result_valid(rv), .rd_ready(rd_ready), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .cycle_count(s_cycle_count), .issue_cnt(s_issue_cnt), .result_cnt(s_result_cnt),
    .drop_cnt(s_drop_cnt), .full(s_full), .empty(s_empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: occupancy, expected trace entries, unbounded event counts.
  bit            started = 1'b0;
  int            occ = 0;
  int            popped, free_slots;
  logic [31:0]   m_cyc = '0;
  longint        m_iss [NP];
  longint        m_res [NP];
  longint        m_drop = 0;
  logic [EW-1:0] exp_q [$];

  always @(posedge tb_clk) begin
    if (rst) begin
      started = 1'b1;
      occ = 0;
      exp_q.delete();
      m_cyc = '0;
      m_drop = 0;
      for (int p = 0; p < NP; p++) begin m_iss[p] = 0; m_res[p] = 0; end
    end else begin
      if (clear) begin
        occ = 0;
        exp_q.delete();
        m_drop = 0;
        for (int p = 0; p < NP; p++) begin m_iss[p] = 0; m_res[p] = 0; end
      end else begin
        popped     = (rd_ready && occ > 0) ? 1 : 0;
        free_slots = D - occ;
        if (en) begin
          for (int p = 0; p < NP; p++) begin
            if (iv[p]) begin
              m_iss[p]++;
              if (free_slots > 0) begin
                exp_q.push_back({m_cyc, PW'(p), tags[p*TW +: TW]});
                free_slots--;
                occ++;
              end else begin
                m_drop++;
              end
            end
            if (rv[p]) m_res[p]++;
          end
        end
        occ -= popped;
      end
      if (en) m_cyc = m_cyc + 1;
    end
  end

  // Monitor: flags and counters every cycle, trace entries whenever a pop is presented.
  logic [EW-1:0] head;
  always @(negedge tb_clk) begin
    if (started) begin
      check("rd_valid", {63'd0, rd_valid}, {63'd0, occ > 0});
      check("empty", {63'd0, empty}, {63'd0, occ == 0});
      check("full", {63'd0, full}, {63'd0, occ == D});
      check("s_rd_valid", {63'd0, s_rd_valid}, {63'd0, occ > 0});
      check("s_full", {63'd0, s_full}, {63'd0, occ == D});
      check("cycle_count", 64'(cycle_count), 64'(m_cyc));
      check("s_cycle_count", 64'(s_cycle_count), 64'(m_cyc));
      check("drop_cnt", 64'(drop_cnt), 64'(sat(m_drop, 64'hFFFF_FFFF)));
      check("s_drop_cnt", 64'(s_drop_cnt), 64'(sat(m_drop, 15)));
      for (int p = 0; p < NP; p++) begin
        check($sformatf("issue_cnt[%0d]", p), 64'(issue_cnt[p*CW +: CW]), 64'(sat(m_iss[p], 64'hFFFF_FFFF)));
        check($sformatf("result_cnt[%0d]", p), 64'(result_cnt[p*CW +: CW]), 64'(sat(m_res[p], 64'hFFFF_FFFF)));
        check($sformatf("s_issue_cnt[%0d]", p), 64'(s_issue_cnt[p*SCW +: SCW]), 64'(sat(m_iss[p], 15)));
        check($sformatf("s_result_cnt[%0d]", p), 64'(s_result_cnt[p*SCW +: SCW]), 64'(sat(m_res[p], 15)));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 64'(rd_data), 64'd0);
          if (rd_data == '0) check("unexpected_pop_valid", 64'd1, 64'd0);
        end else begin
          head = exp_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(head));
          check("s_rd_data", 64'(s_rd_data), 64'(head));
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic c, input logic [NP-1:0] i,
                      input logic [NP-1:0] rs, input logic rdy, input logic [NP*TW-1:0] t);
    rst = r; en = e; clear = c; iv = i; rv = rs; rd_ready = rdy; tags = t;
    @(posedge tb_clk);
    #1;
  endtask

  logic [63:0] rnd_tags;

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; iv = '0; rv = '0; rd_ready = 1'b0; tags = '0;
    repeat (2) @(posedge tb_clk);
    #1;

    // Reset state.
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // Idle 5 enabled cycles.
    repeat (5) step(0, 1, 0, 3'b000, 3'b000, 0, '0);
    check("idle_cycle_count", 64'(cycle_count), 64'd5);
    check("idle_empty", {63'd0, empty}, 64'd1);

    // Ports 0 and 2 issue at cycle_count 7.
    repeat (2) step(0, 1, 0, 3'b000, 3'b000, 0, '0);
    step(0, 1, 0, 3'b101, 3'b000, 1, {13'h1F3, 13'h000, 13'h0A1});
    repeat (3) step(0, 1, 0, 3'b000, 3'b000, 1, '0);
    check("two_port_issue_cnt0", 64'(issue_cnt[0 +: CW]), 64'd1);
    check("two_port_issue_cnt2", 64'(issue_cnt[2*CW +: CW]), 64'd1);

    // Fill to DEPTH-1, then a 3-port burst keeps only port 0.
    step(0, 1, 1, 3'b000, 3'b000, 0, '0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 3'b111, 3'b000, 0, 39'($urandom));
    step(0, 1, 0, 3'b111, 3'b000, 0, {13'h111, 13'h222, 13'h333});
    check("fill_full", {63'd0, full}, 64'd1);
    check("fill_drop_cnt", 64'(drop_cnt), 64'd2);
    check("fill_issue_cnt1", 64'(issue_cnt[CW +: CW]), 64'd6);

    // Full with pop and issue together: issue dropped; next cycle it is accepted.
    step(0, 1, 0, 3'b001, 3'b000, 1, {13'h0, 13'h0, 13'h0AA});
    check("fullpop_drop_cnt", 64'(drop_cnt), 64'd3);
    step(0, 1, 0, 3'b001, 3'b000, 0, {13'h0, 13'h0, 13'h0BB});
    check("fullpop_refill", {63'd0, full}, 64'd1);
    check("fullpop_drop_hold", 64'(drop_cnt), 64'd3);

    // Disabled: no capture or counting, reads still drain.
    repeat (4) step(0, 0, 0, 3'b111, 3'b111, 1, 39'($urandom));

    // Clear with 5 entries and nonzero counters.
    step(0, 1, 1, 3'b000, 3'b000, 0, '0);
    step(0, 1, 0, 3'b111, 3'b010, 0, 39'($urandom));
    step(0, 1, 0, 3'b011, 3'b000, 0, 39'($urandom));
    step(0, 1, 1, 3'b000, 3'b000, 0, '0);
    check("clear_empty", {63'd0, empty}, 64'd1);
    check("clear_issue_cnt0", 64'(issue_cnt[0 +: CW]), 64'd0);
    check("clear_result_cnt1", 64'(result_cnt[CW +: CW]), 64'd0);

    // Saturation of the narrow counters.
    for (int k = 0; k < 20; k++) step(0, 1, 0, 3'b010, 3'b000, 1, 39'($urandom));
    check("sat_small_issue_cnt1", 64'(s_issue_cnt[SCW +: SCW]), 64'd15);
    check("sat_wide_issue_cnt1", 64'(issue_cnt[CW +: CW]), 64'd20);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      rnd_tags = {$urandom, $urandom};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           3'($urandom), 3'($urandom), $urandom_range(0, 9) < 6, rnd_tags[NP*TW-1:0]);
    end

    // Drain.
    repeat (20) step(0, 0, 0, 3'b000, 3'b000, 1, '0);
    check("drain_empty", {63'd0, empty}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
